// File: rtl/sort_pkg.sv
// Shared definitions for the sorter front end: lane geometry, pad value and
// the packer state encoding.
package sort_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int N_LANES    = 8;
  localparam int CNT_W      = $clog2(N_LANES) + 1;

  // Padding sorts to the top lanes because it is the largest unsigned value.
  localparam logic [DATA_W_DEF-1:0] PAD_VAL = '1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/sort_input_packer.sv
// Packs a serial valid/ready sample stream into N_LANES-wide vectors for the
// sorter, padding short groups (closed by i_last) with all-ones lanes.
module sort_input_packer #(
  parameter int DATA_W  = sort_pkg::DATA_W_DEF,
  parameter int N_LANES = sort_pkg::N_LANES,
  parameter int CNT_W   = $clog2(N_LANES) + 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [DATA_W-1:0]         i_data,
  input  logic                      i_last,
  output logic [DATA_W*N_LANES-1:0] o_vec,
  output logic                      o_vec_valid,
  output logic [CNT_W-1:0]          o_vec_cnt,
  input  logic                      i_out_ready
);
  import sort_pkg::*;

  localparam logic [DATA_W-1:0] PAD      = '1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_LANES - 1);

  state_t                      state_q;
  state_t                      state_d;
  logic [CNT_W-1:0]            fcnt;
  logic [DATA_W-1:0]           lane_buf [N_LANES];
  logic                        accept;
  logic                        completing;
  logic                        slot_free;
  logic                        load;
  logic                        buf_we;
  logic [DATA_W*N_LANES-1:0]   packed_vec;

  assign o_ready = (state_q == FILL);

  // In HOLD, fcnt still indexes the group's last sample, so the buffer alone
  // rebuilds the vector and the count is fcnt+1 in both load paths.
  always_comb begin
    accept     = i_valid && o_ready;
    completing = accept && ((fcnt == LAST_IDX) || i_last);
    slot_free  = !o_vec_valid || i_out_ready;
    load       = (state_q == FILL) ? (completing && slot_free) : slot_free;
    buf_we     = accept && !(completing && slot_free);
    state_d    = state_q;
    case (state_q)
      FILL:    if (completing && !slot_free) state_d = HOLD;
      HOLD:    if (slot_free) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    packed_vec = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (CNT_W'(k) < fcnt)
        packed_vec[k*DATA_W +: DATA_W] = lane_buf[k];
      else if (CNT_W'(k) == fcnt)
        packed_vec[k*DATA_W +: DATA_W] = (state_q == FILL) ? i_data : lane_buf[k];
      else
        packed_vec[k*DATA_W +: DATA_W] = PAD;
    end
  end

  // Buffer contents above fcnt are never read, so no reset is needed here.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < N_LANES; k++) begin
      if (buf_we && (fcnt == CNT_W'(k)))
        lane_buf[k] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= FILL;
      fcnt        <= '0;
      o_vec       <= '0;
      o_vec_valid <= 1'b0;
      o_vec_cnt   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        o_vec       <= packed_vec;
        o_vec_cnt   <= fcnt + 1'b1;
        o_vec_valid <= 1'b1;
        fcnt        <= '0;
      end else begin
        if (o_vec_valid && i_out_ready)
          o_vec_valid <= 1'b0;
        if ((state_q == FILL) && accept && !completing)
          fcnt <= fcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sort_input_packer.sv
// Bench for sort_input_packer: directed scenarios plus a randomized run
// scored against a queue-based model of group packing.
module tb_sort_input_packer;

  localparam int DW = 8;
  localparam int NL = 8;
  localparam int CW = $clog2(NL) + 1;

  typedef logic [DW-1:0]    sample_t;
  typedef logic [DW*NL-1:0] vec_t;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           i_valid;
  logic           o_ready;
  sample_t        i_data;
  logic           i_last;
  vec_t           o_vec;
  logic           o_vec_valid;
  logic [CW-1:0]  o_vec_cnt;
  logic           i_out_ready;

  int checks = 0;
  int passes = 0;

  sample_t cur_q[$];
  vec_t    exp_vec_q[$];
  int      exp_cnt_q[$];

  sort_input_packer #(.DATA_W(DW), .N_LANES(NL), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_last(i_last), .o_vec(o_vec), .o_vec_valid(o_vec_valid),
    .o_vec_cnt(o_vec_cnt), .i_out_ready(i_out_ready)
  );

  always #5 i_clk = ~i_clk;

  function automatic vec_t pack_group(input sample_t s[$]);
    vec_t v;
    v = '1;
    for (int k = 0; k < s.size(); k++) v[k*DW +: DW] = s[k];
    return v;
  endfunction

  // Drive one cycle; the model records the sample if the handshake completes.
  task automatic step(input logic v, input sample_t d, input logic l, input logic r);
    i_valid = v; i_data = d; i_last = l; i_out_ready = r;
    if (v && o_ready) begin
      cur_q.push_back(d);
      if (cur_q.size() == NL || l) begin
        exp_vec_q.push_back(pack_group(cur_q));
        exp_cnt_q.push_back(cur_q.size());
        cur_q.delete();
      end
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_out_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++; if (o_vec !== '0) $display("[TB] FAIL reset_vec: got %h expected 0", o_vec); else passes++;
    checks++; if (o_vec_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", o_vec_valid); else passes++;
    checks++; if (o_vec_cnt !== '0) $display("[TB] FAIL reset_cnt: got %0d expected 0", o_vec_cnt); else passes++;
    i_rst = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", o_ready); else passes++;
    @(posedge i_clk); #1;
  endtask

  task automatic test_full_group();
    sample_t fg[8] = '{8'h05, 8'h03, 8'h07, 8'h01, 8'h08, 8'h02, 8'h06, 8'h04};
    int ready_bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_ready !== 1'b1) ready_bad++;
      step(1'b1, fg[i], 1'b0, 1'b1);
    end
    checks++; if (ready_bad != 0) $display("[TB] FAIL full_ready: got %0d low cycles expected 0", ready_bad); else passes++;
    checks++; if (o_vec_valid !== 1'b1) $display("[TB] FAIL full_valid: got %b expected 1", o_vec_valid); else passes++;
    checks++; if (o_vec !== 64'h0406020801070305) $display("[TB] FAIL full_vec: got %h expected 0406020801070305", o_vec); else passes++;
    checks++; if (o_vec_cnt !== 4'd8) $display("[TB] FAIL full_cnt: got %0d expected 8", o_vec_cnt); else passes++;
    step(1'b0, '0, 1'b0, 1'b1);
    checks++; if (o_vec_valid !== 1'b0) $display("[TB] FAIL full_consumed: got %b expected 0", o_vec_valid); else passes++;
  endtask

  task automatic test_partial();
    step(1'b1, 8'h10, 1'b0, 1'b1);
    step(1'b1, 8'h20, 1'b0, 1'b1);
    step(1'b1, 8'h30, 1'b1, 1'b1);
    checks++; if (o_vec !== 64'hFFFFFFFFFF302010) $display("[TB] FAIL partial_vec: got %h expected FFFFFFFFFF302010", o_vec); else passes++;
    checks++; if (o_vec_cnt !== 4'd3) $display("[TB] FAIL partial_cnt: got %0d expected 3", o_vec_cnt); else passes++;
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    sample_t second[$];
    int ready_bad = 0;
    for (int i = 1; i <= 16; i++) begin
      if (o_ready !== 1'b1) ready_bad++;
      if (i > 8) second.push_back(sample_t'(i));
      step(1'b1, sample_t'(i), 1'b0, 1'b1);
      if (i == 8) begin
        checks++; if (o_vec_valid !== 1'b1 || o_vec[7:0] !== 8'h01) $display("[TB] FAIL b2b_first: got valid %b lane0 %h expected 1/01", o_vec_valid, o_vec[7:0]); else passes++;
        checks++; if (o_vec_cnt !== 4'd8) $display("[TB] FAIL b2b_first_cnt: got %0d expected 8", o_vec_cnt); else passes++;
      end
    end
    checks++; if (ready_bad != 0) $display("[TB] FAIL b2b_ready: got %0d low cycles expected 0", ready_bad); else passes++;
    checks++; if (o_vec_valid !== 1'b1 || o_vec !== pack_group(second)) $display("[TB] FAIL b2b_second: got %h expected %h", o_vec, pack_group(second)); else passes++;
    checks++; if (o_vec_cnt !== 4'd8) $display("[TB] FAIL b2b_second_cnt: got %0d expected 8", o_vec_cnt); else passes++;
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    sample_t ga[$];
    sample_t gb[$];
    for (int i = 0; i < 8; i++) begin
      ga.push_back(sample_t'(8'h21 + i));
      gb.push_back(sample_t'(8'h31 + i));
    end
    for (int i = 0; i < 8; i++) step(1'b1, ga[i], 1'b0, 1'b0);
    checks++; if (o_vec_valid !== 1'b1 || o_vec !== pack_group(ga)) $display("[TB] FAIL bp_group_a: got %h expected %h", o_vec, pack_group(ga)); else passes++;
    for (int i = 0; i < 8; i++) step(1'b1, gb[i], 1'b0, 1'b0);
    checks++; if (o_ready !== 1'b0) $display("[TB] FAIL bp_ready_low: got %b expected 0", o_ready); else passes++;
    repeat (3) step(1'b1, 8'hEE, 1'b0, 1'b0);
    checks++; if (o_vec !== pack_group(ga) || o_vec_valid !== 1'b1) $display("[TB] FAIL bp_a_stable: got %h expected %h", o_vec, pack_group(ga)); else passes++;
    checks++; if (o_ready !== 1'b0) $display("[TB] FAIL bp_ready_held: got %b expected 0", o_ready); else passes++;
    step(1'b0, '0, 1'b0, 1'b1);
    checks++; if (o_vec_valid !== 1'b1 || o_vec !== pack_group(gb)) $display("[TB] FAIL bp_group_b: got %h expected %h", o_vec, pack_group(gb)); else passes++;
    checks++; if (o_vec_cnt !== 4'd8) $display("[TB] FAIL bp_cnt_b: got %0d expected 8", o_vec_cnt); else passes++;
    checks++; if (o_ready !== 1'b1) $display("[TB] FAIL bp_ready_back: got %b expected 1", o_ready); else passes++;
    step(1'b0, '0, 1'b0, 1'b1);
    checks++; if (o_vec_valid !== 1'b0) $display("[TB] FAIL bp_consumed: got %b expected 0", o_vec_valid); else passes++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(1'b1, sample_t'(8'h40 + i), 1'b0, 1'b1);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    checks++; if (o_vec !== '0 || o_vec_valid !== 1'b0 || o_vec_cnt !== '0) $display("[TB] FAIL rstmid_outputs: got %h/%b/%0d expected 0/0/0", o_vec, o_vec_valid, o_vec_cnt); else passes++;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    cur_q.delete();
    for (int i = 0; i < 8; i++) step(1'b1, sample_t'(8'hA0 + i), 1'b0, 1'b1);
    checks++; if (o_vec !== 64'hA7A6A5A4A3A2A1A0) $display("[TB] FAIL rstmid_vec: got %h expected A7A6A5A4A3A2A1A0", o_vec); else passes++;
    checks++; if (o_vec_cnt !== 4'd8) $display("[TB] FAIL rstmid_cnt: got %0d expected 8", o_vec_cnt); else passes++;
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_gaps();
    int valid_seen = 0;
    step(1'b0, 8'h99, 1'b1, 1'b1);
    step(1'b1, 8'h55, 1'b1, 1'b1);
    checks++; if (o_vec !== 64'hFFFFFFFFFFFFFF55 || o_vec_cnt !== 4'd1) $display("[TB] FAIL gap_single: got %h/%0d expected FFFFFFFFFFFFFF55/1", o_vec, o_vec_cnt); else passes++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h77, 1'b1, 1'b1);
      if (o_vec_valid === 1'b1) valid_seen++;
    end
    checks++; if (valid_seen != 0) $display("[TB] FAIL gap_last_no_valid: got %0d groups expected 0", valid_seen); else passes++;
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b0, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b1, 1'b1);
    checks++; if (o_vec !== 64'hFFFFFFFFFFFF3311 || o_vec_cnt !== 4'd2) $display("[TB] FAIL gap_toggle: got %h/%0d expected FFFFFFFFFFFF3311/2", o_vec, o_vec_cnt); else passes++;
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    vec_t    held_vec;
    logic [CW-1:0] held_cnt;
    logic    hold_chk;
    vec_t    ev;
    int      ec;
    logic    v, l, r;
    sample_t d;
    exp_vec_q.delete();
    exp_cnt_q.delete();
    cur_q.delete();
    for (int n = 0; n < 430; n++) begin
      if (n < 400) begin
        v = ($urandom_range(0, 3) != 0);
        d = sample_t'($urandom);
        l = ($urandom_range(0, 5) == 0);
        r = ($urandom_range(0, 3) != 0);
      end else begin
        v = 1'b0; d = '0; l = 1'b0; r = 1'b1;
      end
      if (o_vec_valid === 1'b1 && r) begin
        checks++;
        if (exp_vec_q.size() == 0) begin
          $display("[TB] FAIL rand_extra_group: got %h expected no group", o_vec);
        end else begin
          ev = exp_vec_q.pop_front();
          ec = exp_cnt_q.pop_front();
          if (o_vec !== ev || o_vec_cnt !== CW'(ec))
            $display("[TB] FAIL rand_group: got %h/%0d expected %h/%0d", o_vec, o_vec_cnt, ev, ec);
          else passes++;
        end
      end
      hold_chk = (o_vec_valid === 1'b1) && !r;
      held_vec = o_vec;
      held_cnt = o_vec_cnt;
      step(v, d, l, r);
      if (hold_chk) begin
        checks++;
        if (o_vec_valid !== 1'b1 || o_vec !== held_vec || o_vec_cnt !== held_cnt)
          $display("[TB] FAIL rand_stable: got %h/%0d expected %h/%0d", o_vec, o_vec_cnt, held_vec, held_cnt);
        else passes++;
      end
    end
    checks++; if (exp_vec_q.size() != 0 || o_vec_valid !== 1'b0) $display("[TB] FAIL rand_drain: got %0d pending expected 0", exp_vec_q.size()); else passes++;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_full_group();
    test_partial();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_gaps();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
